// File: rtl/processorci_bus_pkg.sv
// rtl/processorci_bus_pkg.sv - shared types and helpers for the processorci bus arbiters
//
// Purpose: arbiter state encoding, round-robin pick function and width helpers
// used by processorci_wb_arbiter and processorci_rr_picker.
// Ports: none (package).

package processorci_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Widest request vector rr_pick can scan; pickers zero-extend into it.
    localparam int MAX_MASTERS = 32;

    // Owner index width; a single master still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Timeout counter width: must hold the terminal value itself.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

    // First requester found scanning from last+1 upward, modulo n.
    // The previous owner is examined last, so it wins only when alone.
    // Returns -1 when nothing is requested.
    function automatic int rr_pick(input logic [MAX_MASTERS-1:0] req,
                                   input int last, input int n);
        int pick;
        int idx;
        pick = -1;
        for (int k = 1; k <= MAX_MASTERS; k++) begin
            if (k <= n && pick < 0) begin
                idx = (last + k) % n;
                if (req[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/processorci_rr_picker.sv
// rtl/processorci_rr_picker.sv - combinational round-robin requester selector
//
// Purpose: given a request vector and the previous winner, name the next winner.
// Ports:
//   req   in  N      request vector (N <= MAX_MASTERS)
//   last  in  IDX_W  index of the previous winner
//   valid out 1      at least one request is present
//   idx   out IDX_W  selected requester (0 when valid is low)

module processorci_rr_picker
    import processorci_bus_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [MAX_MASTERS-1:0] req_ext;
    int                     pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_pick(req_ext, int'(last), N);
        valid          = (pick >= 0);
        idx            = valid ? IDX_W'(pick) : '0;
    end

endmodule

// File: rtl/processorci_wb_arbiter.sv
// rtl/processorci_wb_arbiter.sv - N-master round-robin Wishbone arbiter with timeout
//
// Purpose: share the Controller's single Wishbone slave port between NUM_MASTERS
// processor-side masters. A grant is held for a master's whole cyc period; a
// strobe stalled for TIMEOUT_CYCLES cycles is aborted with an error pulse.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i  per-master Wishbone controls (bit k = master k)
//   m_addr_i, m_data_i   packed per-master address / write data (slice k)
//   m_data_o             read data broadcast to every master
//   m_ack_o, m_err_o     ack / timeout error, only towards the owner
//   core_*_o             slave-side controls, address and write data
//   core_data_i          slave read data
//   core_ack_i           slave ack
//   grant_o              one-hot current owner

module processorci_wb_arbiter
    import processorci_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
    output logic [DATA_WIDTH-1:0]             m_data_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              core_cyc_o,
    output logic                              core_stb_o,
    output logic                              core_we_o,
    output logic [ADDR_WIDTH-1:0]             core_addr_o,
    output logic [DATA_WIDTH-1:0]             core_data_o,
    input  logic [DATA_WIDTH-1:0]             core_data_i,
    input  logic                              core_ack_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int                IDX_W      = idx_width(NUM_MASTERS);
    localparam int                CNT_W      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_RESET = IDX_W'(NUM_MASTERS - 1);
    localparam bit                TMO_EN     = (TIMEOUT_CYCLES != 0);

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    busy;
    logic                    owner_cyc, owner_stb, owner_we;
    logic [ADDR_WIDTH-1:0]   owner_addr;
    logic [DATA_WIDTH-1:0]   owner_data;
    logic                    tmo_fire;
    logic [IDX_W-1:0]        pick_last;
    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;

    // Selection for the first grant from IDLE and for re-arbitration on release.
    // While busy the current owner is the reference, so the releasing master
    // is scanned last and only wins when it is the sole requester.
    assign pick_last = busy ? owner_q : last_q;

    processorci_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (m_cyc_i),
        .last  (pick_last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        busy       = (state_q == BUSY);
        owner_cyc  = m_cyc_i[owner_q];
        owner_stb  = m_stb_i[owner_q];
        owner_we   = m_we_i[owner_q];
        owner_addr = m_addr_i[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
        owner_data = m_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        // An ack in the terminal cycle completes the transfer, so it
        // suppresses the abort.
        tmo_fire   = TMO_EN && busy && owner_cyc && owner_stb && !core_ack_i
                     && (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
                end
            end
            BUSY: begin
                if (!owner_cyc || tmo_fire) begin
                    last_d = owner_q;
                    if (pick_valid) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (TMO_EN && owner_stb && !core_ack_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are purely combinational from the registered owner so that
    // handover needs no idle bus cycle and reset clears them at once.
    always_comb begin
        m_data_o    = core_data_i;
        m_ack_o     = '0;
        m_err_o     = '0;
        grant_o     = '0;
        core_cyc_o  = 1'b0;
        core_stb_o  = 1'b0;
        core_we_o   = 1'b0;
        core_addr_o = '0;
        core_data_o = '0;
        if (busy) begin
            grant_o     = NUM_MASTERS'(1) << owner_q;
            core_cyc_o  = owner_cyc && !tmo_fire;
            core_stb_o  = owner_stb && !tmo_fire;
            core_we_o   = owner_we;
            core_addr_o = owner_addr;
            core_data_o = owner_data;
            // A master that dropped cyc has abandoned its transfer; a late
            // slave ack must not reach it.
            m_ack_o[owner_q] = owner_cyc && core_ack_i;
            m_err_o[owner_q] = tmo_fire;
        end
    end

endmodule
